// File: rtl/source_data_serializer_if.sv
// Stream bundle for the serializer: host-side word stream in, PHY-side beat stream out.
// The slave view is taken by the serializer; the master view belongs to whatever drives it.
interface source_data_serializer_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/source_data_serializer.sv
// Splits host words into flash-bus beats of 16/8/4/2/1 bits, reordering lane groups inside each byte
// so that narrow buses see the low byte first and each byte MSB-group first.
module source_data_serializer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               i_mode,
  source_data_serializer_if.slave  bus,
  output logic                     o_busy,
  output logic                     o_mode_err
);

  localparam int WORDS16 = DATA_W / 16;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            r_state, w_stateNext;
  logic [DATA_W-1:0] r_word, w_wordNext;
  logic [DATA_W-1:0] w_reord;
  logic [DATA_W-1:0] w_beatMask;
  logic [2:0]        r_sel, w_selNext;
  logic [2:0]        w_newSel;
  logic              w_newIllegal;
  logic [CNT_W-1:0]  r_k, w_kNext;
  logic [CNT_W-1:0]  w_lastK;
  logic              r_last, w_lastNext;
  logic              r_modeErr, w_modeErrNext;
  logic [4:0]        w_lw;
  logic              w_accept;
  logic              w_beatDone;
  logic              w_finalBeat;

  // r_sel holds log2(16/LW); illegal modes collapse to the 16-bit lane
  assign w_newIllegal = (i_mode > 3'd4);
  assign w_newSel     = w_newIllegal ? 3'd0 : i_mode;

  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
    logic [7:0] w_in;
    assign w_in = bus.s_data[b*8 +: 8];
    assign w_reord[b*8 +: 8] =
      (w_newSel == 3'd2) ? {w_in[3:0], w_in[7:4]} :
      (w_newSel == 3'd3) ? {w_in[1:0], w_in[3:2], w_in[5:4], w_in[7:6]} :
      (w_newSel == 3'd4) ? {w_in[0], w_in[1], w_in[2], w_in[3],
                            w_in[4], w_in[5], w_in[6], w_in[7]} :
                           w_in;
  end

  assign w_lw    = 5'd16 >> r_sel;
  assign w_lastK = CNT_W'((WORDS16 << r_sel) - 1);

  always_comb begin
    w_beatMask        = '0;
    w_beatMask[15:0]  = 16'((32'd1 << w_lw) - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_word    <= '0;
      r_sel     <= 3'd0;
      r_k       <= '0;
      r_last    <= 1'b0;
      r_modeErr <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_word    <= w_wordNext;
      r_sel     <= w_selNext;
      r_k       <= w_kNext;
      r_last    <= w_lastNext;
      r_modeErr <= w_modeErrNext;
    end
  end

  // The held word is shifted down by LW per accepted beat, so the current beat always sits at bit 0
  always_comb begin
    w_stateNext   = r_state;
    w_wordNext    = r_word;
    w_selNext     = r_sel;
    w_kNext       = r_k;
    w_lastNext    = r_last;
    w_modeErrNext = r_modeErr;

    w_finalBeat = (r_k == w_lastK);
    bus.s_ready = (r_state == IDLE) | (bus.m_ready & w_finalBeat);
    w_accept    = bus.s_valid & bus.s_ready;
    w_beatDone  = (r_state == SHIFT) & bus.m_ready;

    if (w_accept) begin
      w_stateNext   = SHIFT;
      w_wordNext    = w_reord;
      w_selNext     = w_newSel;
      w_kNext       = '0;
      w_lastNext    = bus.s_last;
      w_modeErrNext = r_modeErr | w_newIllegal;
    end else if (w_beatDone) begin
      if (w_finalBeat) begin
        w_stateNext = IDLE;
        w_wordNext  = '0;
        w_kNext     = '0;
      end else begin
        w_wordNext = r_word >> w_lw;
        w_kNext    = r_k + CNT_W'(1);
      end
    end

    bus.m_valid = (r_state == SHIFT);
    bus.m_data  = r_word & w_beatMask;
    bus.m_last  = (r_state == SHIFT) & r_last & w_finalBeat;
    o_busy      = (r_state == SHIFT);
    o_mode_err  = r_modeErr;
  end

endmodule

// File: tb/tb_source_data_serializer.sv
// Bench for source_data_serializer: fixed vector table, hand-built timing sequences, and random traffic
// scored against a byte/lane-group reference model.
module tb_source_data_serializer;

  localparam int DATA_W = 16;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] data;
    logic        last;
    int          n;
    logic [15:0] beats [16];
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic       busy;
  logic       modeErr;

  int    nCompared   = 0;
  int    nMismatched = 0;
  beat_t expQ [$];
  logic  modelErr    = 1'b0;
  logic        stallPrev = 1'b0;
  logic [15:0] stallData;
  logic        stallLast;

  source_data_serializer_if #(.DATA_W(DATA_W)) bus ();

  source_data_serializer #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_mode     (mode),
    .bus        (bus.slave),
    .o_busy     (busy),
    .o_mode_err (modeErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] md, input logic [15:0] d,
                               input logic l, input logic r);
    bus.s_valid = v;
    mode        = md;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.m_ready = r;
  endtask

  // Reference: reverse the order of LW-bit groups inside each byte, then cut into LW-bit beats from bit 0 up
  function automatic void modelPush(input logic [15:0] d, input logic [2:0] md, input logic l);
    int          lw;
    int          groups;
    int          n;
    logic [15:0] f;
    beat_t       bt;
    lw = (md <= 3'd4) ? (16 >> md) : 16;
    f  = d;
    if (lw < 8) begin
      groups = 8 / lw;
      for (int b = 0; b < 2; b++)
        for (int g = 0; g < groups; g++)
          for (int p = 0; p < lw; p++)
            f[b*8 + g*lw + p] = d[b*8 + (groups-1-g)*lw + p];
    end
    n = 16 / lw;
    for (int k = 0; k < n; k++) begin
      bt.data = '0;
      for (int p = 0; p < lw; p++) bt.data[p] = f[k*lw + p];
      bt.last = l && (k == n - 1);
      expQ.push_back(bt);
    end
  endfunction

  // Scoreboard: sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    beat_t expBeat;
    if (stallPrev && !rst) begin
      checkOutput("holdValid", bus.m_valid, 1'b1);
      checkOutput("holdData", bus.m_data, stallData);
      checkOutput("holdLast", bus.m_last, stallLast);
    end
    checkOutput("modeErr", modeErr, modelErr);
    if (rst) begin
      expQ.delete();
      modelErr  = 1'b0;
      stallPrev = 1'b0;
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpectedBeat: got data 0x%0h, expected no beat at %0t", bus.m_data, $time);
        end else begin
          expBeat = expQ.pop_front();
          checkOutput("beatData", bus.m_data, expBeat.data);
          checkOutput("beatLast", bus.m_last, expBeat.last);
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        modelPush(bus.s_data, mode, bus.s_last);
        if (mode > 3'd4) modelErr = 1'b1;
      end
      stallPrev = bus.m_valid && !bus.m_ready;
      stallData = bus.m_data;
      stallLast = bus.m_last;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [6];
    logic [15:0] wordsA [4];
    int          r;
    int          drainCycles;

    foreach (vecs[v]) begin
      vecs[v].mode = 3'd0;
      vecs[v].data = '0;
      vecs[v].last = 1'b0;
      vecs[v].n    = 1;
      foreach (vecs[v].beats[b]) vecs[v].beats[b] = 16'h0000;
    end
    vecs[0].mode = 3'd1; vecs[0].data = 16'h1234; vecs[0].last = 1'b0; vecs[0].n = 2;
    vecs[0].beats[0] = 16'h0034; vecs[0].beats[1] = 16'h0012;
    vecs[1].mode = 3'd2; vecs[1].data = 16'h1234; vecs[1].last = 1'b1; vecs[1].n = 4;
    vecs[1].beats[0] = 16'h0003; vecs[1].beats[1] = 16'h0004;
    vecs[1].beats[2] = 16'h0001; vecs[1].beats[3] = 16'h0002;
    vecs[2].mode = 3'd4; vecs[2].data = 16'h0080; vecs[2].last = 1'b0; vecs[2].n = 16;
    vecs[2].beats[0] = 16'h0001;
    vecs[3].mode = 3'd3; vecs[3].data = 16'h1234; vecs[3].last = 1'b1; vecs[3].n = 8;
    vecs[3].beats[1] = 16'h0003; vecs[3].beats[2] = 16'h0001;
    vecs[3].beats[5] = 16'h0001; vecs[3].beats[7] = 16'h0002;
    vecs[4].mode = 3'd0; vecs[4].data = 16'hABCD; vecs[4].last = 1'b1; vecs[4].n = 1;
    vecs[4].beats[0] = 16'hABCD;
    vecs[5].mode = 3'd4; vecs[5].data = 16'h00A5; vecs[5].last = 1'b1; vecs[5].n = 16;
    vecs[5].beats[0] = 16'h0001; vecs[5].beats[2] = 16'h0001;
    vecs[5].beats[5] = 16'h0001; vecs[5].beats[7] = 16'h0001;

    wordsA[0] = 16'hABCD; wordsA[1] = 16'h1111; wordsA[2] = 16'h2222; wordsA[3] = 16'h3333;

    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstValid", bus.m_valid, 1'b0);
    checkOutput("rstData", bus.m_data, 16'h0000);
    checkOutput("rstLast", bus.m_last, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstModeErr", modeErr, 1'b0);
    checkOutput("rstReady", bus.s_ready, 1'b1);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      applyStimulus(1'b1, vecs[v].mode, vecs[v].data, vecs[v].last, 1'b1);
      checkOutput($sformatf("tbl%0d.readyIdle", v), bus.s_ready, 1'b1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
      for (int b = 0; b < vecs[v].n; b++) begin
        checkOutput($sformatf("tbl%0d.valid%0d", v, b), bus.m_valid, 1'b1);
        checkOutput($sformatf("tbl%0d.data%0d", v, b), bus.m_data, vecs[v].beats[b]);
        checkOutput($sformatf("tbl%0d.last%0d", v, b), bus.m_last, vecs[v].last && (b == vecs[v].n - 1));
        checkOutput($sformatf("tbl%0d.ready%0d", v, b), bus.s_ready, (b == vecs[v].n - 1));
        checkOutput($sformatf("tbl%0d.busy%0d", v, b), busy, 1'b1);
        @(posedge clk); #1;
      end
      checkOutput($sformatf("tbl%0d.idle", v), bus.m_valid, 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'd0, wordsA[i], 1'b0, 1'b1);
      checkOutput($sformatf("b2b.ready%0d", i), bus.s_ready, 1'b1);
      if (i > 0) begin
        checkOutput($sformatf("b2b.valid%0d", i), bus.m_valid, 1'b1);
        checkOutput($sformatf("b2b.data%0d", i), bus.m_data, wordsA[i-1]);
      end
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
    checkOutput("b2b.valid4", bus.m_valid, 1'b1);
    checkOutput("b2b.data4", bus.m_data, wordsA[3]);
    @(posedge clk); #1;
    checkOutput("b2b.idle", bus.m_valid, 1'b0);

    applyStimulus(1'b1, 3'd1, 16'h1234, 1'b0, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("stall.valid%0d", c), bus.m_valid, 1'b1);
      checkOutput($sformatf("stall.data%0d", c), bus.m_data, 16'h0034);
      checkOutput($sformatf("stall.ready%0d", c), bus.s_ready, 1'b0);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0, 1'b1);
    checkOutput("stall.dataHeld", bus.m_data, 16'h0034);
    @(posedge clk); #1;
    checkOutput("stall.beat1", bus.m_data, 16'h0012);
    applyStimulus(1'b1, 3'd4, 16'h0080, 1'b1, 1'b1);
    checkOutput("stall.readyFinal", bus.s_ready, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0, 1'b1);
    checkOutput("stall.nextBeat0", bus.m_data, 16'h0001);
    checkOutput("stall.nextLast0", bus.m_last, 1'b0);
    @(posedge clk); #1;
    for (int c = 1; c < 16; c++) begin
      checkOutput($sformatf("stall.nextValid%0d", c), bus.m_valid, 1'b1);
      checkOutput($sformatf("stall.nextData%0d", c), bus.m_data, 16'h0000);
      checkOutput($sformatf("stall.nextLast%0d", c), bus.m_last, (c == 15));
      @(posedge clk); #1;
    end
    checkOutput("stall.idle", bus.m_valid, 1'b0);

    applyStimulus(1'b1, 3'd6, 16'h1234, 1'b0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
    checkOutput("illegal.valid", bus.m_valid, 1'b1);
    checkOutput("illegal.data", bus.m_data, 16'h1234);
    checkOutput("illegal.err", modeErr, 1'b1);
    @(posedge clk); #1;
    checkOutput("illegal.single", bus.m_valid, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("illegal.sticky", modeErr, 1'b1);
    end
    applyStimulus(1'b1, 3'd4, 16'hFFFF, 1'b0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midRst.busyBefore", bus.m_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midRst.valid", bus.m_valid, 1'b0);
    checkOutput("midRst.err", modeErr, 1'b0);
    checkOutput("midRst.ready", bus.s_ready, 1'b1);
    checkOutput("midRst.data", bus.m_data, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midRst.discarded", bus.m_valid, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 11);
      applyStimulus(($urandom_range(0, 9) < 6), (r < 10) ? 3'(r % 5) : 3'($urandom_range(5, 7)),
                    16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
    drainCycles = 0;
    while (bus.m_valid && drainCycles < 40) begin
      @(posedge clk); #1;
      drainCycles++;
    end
    checkOutput("drain.idle", bus.m_valid, 1'b0);
    @(negedge clk); #1;
    checkOutput("drain.queueEmpty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/source_data_serializer.md
Name: source_data_serializer

Overview:
- Successor to the fixed-width flash-bus source formatter. Accepts parallel host words over a valid/ready stream and applies the per-lane-width bit reordering.
- Serialises each word into beats sized to the runtime-selected flash bus width: 16, 8, 4, 2 or 1 bit.
- Sits between the write-data buffer and the flash PHY lane drivers.
- Adds what the combinational formatter lacks: data-width parameterisation, mode latching, beat sequencing, backpressure and frame marking.

Parameters:
- DATA_W, 16, input word width; must be a multiple of 16 (16 or 32 supported).
- CNT_W, $clog2(DATA_W)+1, beat counter width; derived, do not override.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mode  in  3  lane width select: 0=16b, 1=8b, 2=4b, 3=2b, 4=1b; 5..7 illegal.
- s_valid  in  1  input word valid.
- s_ready  out  1  serializer can accept a word this cycle.
- s_data  in  DATA_W  input word.
- s_last  in  1  word is last of frame.
- m_valid  out  1  output beat valid.
- m_ready  in  1  PHY accepts beat.
- m_data  out  DATA_W  beat; active bits [LW-1:0], upper bits driven 0.
- m_last  out  1  final beat of a word flagged s_last.
- busy  out  1  word held (m_valid high).
- mode_err  out  1  sticky: an illegal mode was latched.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: m_valid=0, m_data=0, m_last=0, busy=0, mode_err=0, beat counter=0, latched LW=16. s_ready=1 out of reset.
- Reset mid-word discards the held word and its remaining beats. No beat is emitted in the cycle after rst.
- Lane width: LW is the width selected by mode.
- mode latching:
  - mode is sampled only on word acceptance (s_valid & s_ready).
  - Changes while a word is held have no effect on that word.
  - An illegal mode latches LW=16 and sets mode_err until rst.
- Reordering, applied at acceptance:
  - LW>=8: identity.
  - LW<8: within every byte of s_data, the LW-bit groups are reversed in order; bytes keep their positions.
  - Example, LW=4, 16-bit word: F = {d[11:8], d[15:12], d[3:0], d[7:4]}.
  - LW=1 bit-reverses each byte.
- Beats:
  - N = DATA_W/LW beats per word.
  - Beat k (0..N-1): m_data[LW-1:0] = F[k*LW +: LW]; remaining bits are 0.
  - Result: low byte first, MSB of each byte first on narrow buses.
- States: IDLE (no word held) and SHIFT (word held, m_valid=1).
  - IDLE -> SHIFT on acceptance; first beat is registered, so m_valid rises the cycle after acceptance (1-cycle latency).
  - In SHIFT, each m_valid & m_ready advances k.
  - On the final beat (k=N-1) handshake:
    - If s_valid is high, the next word loads in the same cycle and the state stays SHIFT.
    - Otherwise the state returns to IDLE.
- s_ready = (state==IDLE) | (m_ready & k==N-1). This is combinational from m_ready, with no bubble between words. Mode 0 at DATA_W=16 sustains 1 word/cycle.
- Holding rules:
  - m_ready low holds m_data, m_last and k stable.
  - m_valid never drops without a handshake.
- m_last = latched s_last & (k==N-1).
- busy = m_valid.
- Simultaneous final-beat handshake and new acceptance:
  - New word's beat 0 appears next cycle.
  - New mode applies to it.
  - m_last of the previous word has been consumed.

Test Plan:
- DATA_W=16, mode=1, s_data=0x1234, m_ready=1 -> beats m_data=0x0034 then 0x0012; s_ready low for 1 cycle; m_last=0 (s_last=0).
- mode=2, s_data=0x1234, s_last=1 -> beats 0x0003, 0x0004, 0x0001, 0x0002; m_last only on 4th beat.
- mode=4, s_data=0x0080 -> 16 beats: first m_data=0x0001, remaining fifteen 0x0000; busy high for 16 cycles.
- mode=0, 4 back-to-back words 0xABCD, 0x1111, 0x2222, 0x3333 with m_ready=1 -> 4 consecutive m_valid cycles, identical data, s_ready never low.
- mode=1, m_ready held low 5 cycles mid-word, mode switched to 4 during stall -> m_data frozen; remaining beats still 8-bit; next word uses 1-bit.
- mode=6 on accept -> mode_err=1 and stays high; word emitted as single 16-bit beat. Then rst asserted mid-word in mode 4 -> next cycle m_valid=0, mode_err=0, s_ready=1.
